// File: rtl/mbist_march_if.sv
// Bundle between the March C- controller and its SRAM / comparator / host.
// master = controller, slave = environment (memory, comparator, host).
interface mbist_march_if #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32
);
    logic               bist_en;
    logic               bist_run;
    logic [DATA_WD-1:0] pat_data;
    logic               mem_cs;
    logic               mem_we;
    logic [ADDR_WD-1:0] mem_addr;
    logic [DATA_WD-1:0] mem_wdata;
    logic               cmp_compare;
    logic               cmp_read_invert;
    logic [DATA_WD-1:0] cmp_data;
    logic [ADDR_WD-1:0] cmp_addr;
    logic               cmp_error;
    logic               cmp_error_fix;
    logic               bist_busy;
    logic               bist_done;
    logic               bist_pass;
    logic [2:0]         fail_step;
    logic [3:0]         fix_cnt;

    modport master (
        input  bist_en, bist_run, pat_data, cmp_error, cmp_error_fix,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        output cmp_compare, cmp_read_invert, cmp_data, cmp_addr,
        output bist_busy, bist_done, bist_pass, fail_step, fix_cnt
    );

    modport slave (
        output bist_en, bist_run, pat_data, cmp_error, cmp_error_fix,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        input  cmp_compare, cmp_read_invert, cmp_data, cmp_addr,
        input  bist_busy, bist_done, bist_pass, fail_step, fix_cnt
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer for one SRAM: issues one op per cycle, forwards each read to
// the comparator a cycle later and stops on an unrepairable compare error.
module mbist_march_ctrl #(
    parameter int BIST_ADDR_WD = 9,
    parameter int BIST_DATA_WD = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mbist_march_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [BIST_ADDR_WD-1:0] ADDR_MAX = '1;

    state_t                  state_q, state_d;
    logic [2:0]              step_q;
    logic [BIST_ADDR_WD-1:0] addr_q;
    logic                    op_q;
    logic                    drain_q;
    logic                    cmp_vld_q;
    logic                    cmp_inv_q;
    logic [BIST_ADDR_WD-1:0] cmp_addr_q;
    logic [2:0]              step_p1_q, step_p2_q;
    logic                    done_q, pass_q;
    logic [2:0]              fail_step_q;
    logic [3:0]              fix_cnt_q;

    logic busy, start, is_read, rd_inv, wr_inv, op_last, addr_last, run_last;

    // Element table: S0 {w0}, S1 {r0,w1}, S2 {r1,w0}, S3 {r0,w1}, S4 {r1,w0}, S5 {r0}.
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.bist_en && bus.bist_run;
    assign is_read   = (step_q != 3'd0) && !op_q;
    assign rd_inv    = (step_q == 3'd2) || (step_q == 3'd4);
    assign wr_inv    = (step_q == 3'd1) || (step_q == 3'd3);
    assign op_last   = ((step_q == 3'd0) || (step_q == 3'd5)) ? 1'b1 : op_q;
    assign addr_last = addr_q == ((step_q >= 3'd3) ? '0 : ADDR_MAX);
    assign run_last  = (step_q == 3'd5) && op_last && addr_last;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.cmp_error)  state_d = ST_DONE;
                else if (run_last)  state_d = ST_DRAIN;
            end
            ST_DRAIN: if (bus.cmp_error || drain_q) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (!bus.bist_en) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            addr_q      <= '0;
            op_q        <= 1'b0;
            drain_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_inv_q   <= 1'b0;
            cmp_addr_q  <= '0;
            step_p1_q   <= '0;
            step_p2_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_step_q <= '0;
            fix_cnt_q   <= '0;
        end else begin
            // step_p2_q lines up with cmp_error, two cycles after the read it judges.
            step_p1_q <= step_q;
            step_p2_q <= step_p1_q;
            cmp_vld_q <= (state_q == ST_RUN) && is_read;
            if ((state_q == ST_RUN) && is_read) begin
                cmp_inv_q  <= rd_inv;
                cmp_addr_q <= addr_q;
            end
            drain_q <= (state_q == ST_DRAIN);
            done_q  <= (state_d == ST_DONE);

            if (start) begin
                step_q      <= '0;
                addr_q      <= '0;
                op_q        <= 1'b0;
                pass_q      <= 1'b0;
                fail_step_q <= '0;
                fix_cnt_q   <= '0;
            end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
                if (!op_last) begin
                    op_q <= 1'b1;
                end else begin
                    op_q <= 1'b0;
                    if (addr_last) begin
                        step_q <= step_q + 3'd1;
                        addr_q <= ((step_q + 3'd1) >= 3'd3) ? ADDR_MAX : '0;
                    end else begin
                        addr_q <= (step_q >= 3'd3) ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end
            end

            if (busy && (state_d == ST_DONE)) begin
                pass_q <= !bus.cmp_error;
                if (bus.cmp_error) fail_step_q <= step_p2_q;
            end
            if (busy && bus.cmp_error_fix && (fix_cnt_q != 4'hf))
                fix_cnt_q <= fix_cnt_q + 4'd1;
        end
    end

    assign bus.mem_cs          = (state_q == ST_RUN);
    assign bus.mem_we          = bus.mem_cs && !is_read;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wdata       = bus.mem_we ? (wr_inv ? ~bus.pat_data : bus.pat_data) : '0;
    assign bus.cmp_compare     = cmp_vld_q && busy;
    assign bus.cmp_read_invert = cmp_inv_q && bus.cmp_compare;
    assign bus.cmp_data        = busy ? bus.pat_data : '0;
    assign bus.cmp_addr        = cmp_addr_q;
    assign bus.bist_busy       = busy;
    assign bus.bist_done       = done_q;
    assign bus.bist_pass       = pass_q;
    assign bus.fail_step       = fail_step_q;
    assign bus.fix_cnt         = fix_cnt_q;
endmodule
